// File: rtl/fir_drain_pkg.sv
// Shared defaults, parameter legality checks and helpers for the FIR result drain.
package fir_drain_pkg;

    localparam int unsigned DFLT_DATA_W    = 32;
    localparam int unsigned DFLT_RD_LAT    = 1;
    localparam int unsigned DFLT_BUF_DEPTH = 4;
    localparam int unsigned DFLT_CNT_W     = 16;
    localparam int unsigned RD_LAT_MIN     = 1;
    localparam int unsigned RD_LAT_MAX     = 3;
    localparam int unsigned ABS_W          = 64;

    function automatic logic rd_lat_ok(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic logic depth_ok(input int unsigned depth, input int unsigned lat);
        return (depth != 0) && ((depth & (depth - 1)) == 0) && (depth >= lat + 1);
    endfunction

    // Magnitude of a sign-extended w-bit value, saturated to 2^(w-1)-1.
    function automatic logic [ABS_W-1:0] abs_sat(input logic [ABS_W-1:0] val,
                                                 input int unsigned w);
        logic [ABS_W-1:0] lim;
        logic [ABS_W-1:0] mag;
        lim = (ABS_W'(1) << (w - 1)) - ABS_W'(1);
        mag = val[ABS_W-1] ? (~val + ABS_W'(1)) : val;
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/fir_drain_buf.sv
// Power-of-two circular buffer with occupancy count; head entry is read straight from storage.
module fir_drain_buf
    import fir_drain_pkg::*;
#(
    parameter int unsigned DATA_W = DFLT_DATA_W,
    parameter int unsigned DEPTH  = DFLT_BUF_DEPTH
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage is cleared too so the head reads as zero out of reset.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_result_drain.sv
// FIR output FIFO drain: credit-gated pops, read-latency absorption, decimation, valid/ready out.
// Optional peak-magnitude tracker is compiled in with FIR_DRAIN_PEAK_EN.
module fir_result_drain
    import fir_drain_pkg::*;
#(
    parameter int unsigned DATA_W    = DFLT_DATA_W,
    parameter int unsigned RD_LAT    = DFLT_RD_LAT,
    parameter int unsigned BUF_DEPTH = DFLT_BUF_DEPTH,
    parameter int unsigned CNT_W     = DFLT_CNT_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_req_get,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic [3:0]        decim,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              busy
`ifdef FIR_DRAIN_PEAK_EN
    ,
    output logic [DATA_W-2:0] peak_abs,
    input  logic              peak_clr
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    logic [RD_LAT-1:0] inflight;
    logic [3:0]        phase;
    logic [3:0]        decim_latched;
    logic [CW-1:0]     buf_count;
    logic              buf_full;
    logic              buf_empty;
    logic [31:0]       credit_used;
    logic              capture;
    logic              keep;
    logic              pop;

    // Every outstanding read already owns a buffer slot, so a capture never overflows.
    assign credit_used  = 32'(buf_count) + 32'($countones(inflight));
    assign fifo_req_get = ~reset & enable & ~fifo_empty & (credit_used < BUF_DEPTH);
    assign capture      = inflight[RD_LAT-1];
    assign keep         = capture & (phase == 4'd0);
    assign m_valid      = ~buf_empty;
    assign pop          = m_valid & m_ready;
    assign busy         = (inflight != '0) | ~buf_empty;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            inflight      <= '0;
            phase         <= 4'd0;
            decim_latched <= 4'd0;
            sample_cnt    <= '0;
        end else begin
            inflight <= RD_LAT'({inflight, fifo_req_get});
            if (!busy) begin
                decim_latched <= decim;
            end
            // Wrap on >= so a ratio change seen between bursts cannot strand phase.
            if (capture) begin
                phase <= (phase >= decim_latched) ? 4'd0 : phase + 4'd1;
            end
            if (pop) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

    fir_drain_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .CLK     (CLK),
        .reset   (reset),
        .wr_en   (keep),
        .wr_data (fifo_data),
        .rd_en   (pop),
        .rd_data (m_data),
        .count   (buf_count),
        .full    (buf_full),
        .empty   (buf_empty)
    );

`ifdef FIR_DRAIN_PEAK_EN
    logic [DATA_W-2:0] wr_abs;

    assign wr_abs = (DATA_W-1)'(abs_sat(ABS_W'($signed(fifo_data)), DATA_W));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            peak_abs <= '0;
        end else if (peak_clr) begin
            peak_abs <= '0;
        end else if (keep && (wr_abs > peak_abs)) begin
            peak_abs <= wr_abs;
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge CLK) disable iff (reset) !(capture && buf_full))
        else $error("fir_result_drain: capture into a full buffer");
    a_params: assert property (@(posedge CLK) disable iff (reset)
                               rd_lat_ok(RD_LAT) && depth_ok(BUF_DEPTH, RD_LAT))
        else $error("fir_result_drain: illegal RD_LAT/BUF_DEPTH");
`endif

endmodule

// File: tb/tb_fir_result_drain.sv
// Directed bench for fir_result_drain: RD_LAT=1 and RD_LAT=3 instances, each fed by a FIFO model.
module tb_fir_result_drain;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  decim;
    logic        m_ready;
    logic        peak_clr;
    logic        force_empty3;

    logic        empty1, req1, mv1, busy1;
    logic [31:0] fdata1, md1;
    logic [15:0] cnt1;
    logic        empty3, req3, mv3, busy3;
    logic [31:0] fdata3, md3, pa3, pb3;
    logic [15:0] cnt3;
`ifdef FIR_DRAIN_PEAK_EN
    logic [30:0] peak1, peak3;
`endif

    logic [31:0] src1 [128];
    logic [31:0] src3 [128];
    int          wr1, rd1, pops1;
    int          wr3, rd3, pops3;
    logic [31:0] r1 [$];
    logic [31:0] r3 [$];
    int          checks, errors;
    int          base;

    assign empty1 = (rd1 >= wr1);
    assign empty3 = (rd3 >= wr3) || force_empty3;

    fir_result_drain #(.DATA_W(32), .RD_LAT(1), .BUF_DEPTH(4), .CNT_W(16)) dut1 (
        .CLK(clk), .reset(reset), .enable(enable), .fifo_empty(empty1),
        .fifo_req_get(req1), .fifo_data(fdata1), .decim(decim),
        .m_data(md1), .m_valid(mv1), .m_ready(m_ready),
        .sample_cnt(cnt1), .busy(busy1)
`ifdef FIR_DRAIN_PEAK_EN
        , .peak_abs(peak1), .peak_clr(peak_clr)
`endif
    );

    fir_result_drain #(.DATA_W(32), .RD_LAT(3), .BUF_DEPTH(4), .CNT_W(16)) dut3 (
        .CLK(clk), .reset(reset), .enable(enable), .fifo_empty(empty3),
        .fifo_req_get(req3), .fifo_data(fdata3), .decim(decim),
        .m_data(md3), .m_valid(mv3), .m_ready(m_ready),
        .sample_cnt(cnt3), .busy(busy3)
`ifdef FIR_DRAIN_PEAK_EN
        , .peak_abs(peak3), .peak_clr(peak_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO read side with latency 1; idle cycles present garbage to expose wrong capture timing.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1    <= wr1;
            fdata1 <= 32'h0;
        end else if (req1) begin
            fdata1 <= src1[rd1];
            rd1    <= rd1 + 1;
            pops1  <= pops1 + 1;
        end else begin
            fdata1 <= 32'hDEAD_BEEF;
        end
    end

    // FIFO read side with latency 3.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd3    <= wr3;
            pa3    <= 32'h0;
            pb3    <= 32'h0;
            fdata3 <= 32'h0;
        end else begin
            if (req3) begin
                pa3   <= src3[rd3];
                rd3   <= rd3 + 1;
                pops3 <= pops3 + 1;
            end else begin
                pa3 <= 32'hDEAD_BEEF;
            end
            pb3    <= pa3;
            fdata3 <= pb3;
        end
    end

    always @(posedge clk) begin
        if (!reset && mv1 && m_ready) r1.push_back(md1);
        if (!reset && mv3 && m_ready) r3.push_back(md3);
    end

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; m_ready = 1'b0; decim = 4'd0;
        peak_clr = 1'b0; force_empty3 = 1'b0;
        @(negedge clk);
        checks++; if (req1 !== 1'b0) begin errors++; $display("FAIL rst_req got %h exp 0", req1); end
        checks++; if (mv1 !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %h exp 0", mv1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy got %h exp 0", busy1); end
        checks++; if (md1 !== 32'h0) begin errors++; $display("FAIL rst_m_data got %h exp 0", md1); end
        checks++; if (cnt1 !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", cnt1); end
        // Load dut3 and stall output so reads pile up: 2 buffered + 2 in flight after 5 cycles.
        for (int i = 0; i < 8; i++) src3[wr3 + i] = 32'h30 + 32'(i);
        wr3 = wr3 + 8;
        enable = 1'b1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL mid_busy got %h exp 1", busy3); end
        checks++; if (mv3 !== 1'b1) begin errors++; $display("FAIL mid_m_valid got %h exp 1", mv3); end
        checks++; if (md3 !== 32'h30) begin errors++; $display("FAIL mid_m_data got %h exp 30", md3); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mv3 !== 1'b0) begin errors++; $display("FAIL arst_m_valid got %h exp 0", mv3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL arst_busy got %h exp 0", busy3); end
        checks++; if (md3 !== 32'h0) begin errors++; $display("FAIL arst_m_data got %h exp 0", md3); end
        checks++; if (cnt3 !== 16'h0) begin errors++; $display("FAIL arst_cnt got %h exp 0", cnt3); end
        checks++; if (req3 !== 1'b0) begin errors++; $display("FAIL arst_req got %h exp 0", req3); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        r1.delete();
        m_ready = 1'b1; enable = 1'b1; decim = 4'd0;
        for (int i = 0; i < 10; i++) src1[wr1 + i] = 32'(i + 1);
        wr1 = wr1 + 10;
        for (int c = 0; c < 100 && r1.size() < 10; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (r1.size() != 10) begin errors++; $display("FAIL basic_count got %0d exp 10", r1.size()); end
        for (int i = 0; i < 10 && i < r1.size(); i++) begin
            checks++;
            if (r1[i] !== 32'(i + 1)) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, r1[i], 32'(i + 1)); end
        end
        checks++; if (cnt1 !== 16'd10) begin errors++; $display("FAIL basic_cnt got %0d exp 10", cnt1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL basic_busy got %h exp 0", busy1); end
    endtask

    task automatic test_backpressure();
        r1.delete();
        m_ready = 1'b0;
        base = pops1;
        for (int i = 0; i < 20; i++) src1[wr1 + i] = 32'h100 + 32'(i);
        wr1 = wr1 + 20;
        repeat (20) @(negedge clk);
        checks++; if (pops1 - base != 4) begin errors++; $display("FAIL bp_pops got %0d exp 4", pops1 - base); end
        checks++; if (req1 !== 1'b0) begin errors++; $display("FAIL bp_req got %h exp 0", req1); end
        checks++; if (md1 !== 32'h100) begin errors++; $display("FAIL bp_head got %h exp 100", md1); end
        repeat (5) @(negedge clk);
        checks++; if (req1 !== 1'b0 || pops1 - base != 4) begin
            errors++; $display("FAIL bp_hold req %h pops %0d exp req 0 pops 4", req1, pops1 - base);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 200 && r1.size() < 20; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (r1.size() != 20) begin errors++; $display("FAIL bp_count got %0d exp 20", r1.size()); end
        for (int i = 0; i < 20 && i < r1.size(); i++) begin
            checks++;
            if (r1[i] !== 32'h100 + 32'(i)) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, r1[i], 32'h100 + 32'(i)); end
        end
        checks++; if (cnt1 !== 16'd30) begin errors++; $display("FAIL bp_cnt got %0d exp 30", cnt1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL bp_busy got %h exp 0", busy1); end
    endtask

    task automatic test_decim();
        r1.delete();
        m_ready = 1'b1;
        decim = 4'd2;
        for (int i = 0; i < 9; i++) src1[wr1 + i] = 32'(i);
        wr1 = wr1 + 9;
        repeat (3) @(negedge clk);
        decim = 4'd0;
        for (int c = 0; c < 100 && !(r1.size() >= 3 && !busy1); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (r1.size() != 3) begin errors++; $display("FAIL dec_count got %0d exp 3", r1.size()); end
        for (int i = 0; i < 3 && i < r1.size(); i++) begin
            checks++;
            if (r1[i] !== 32'(3 * i)) begin errors++; $display("FAIL dec_data[%0d] got %h exp %h", i, r1[i], 32'(3 * i)); end
        end
        checks++; if (cnt1 !== 16'd33) begin errors++; $display("FAIL dec_cnt got %0d exp 33", cnt1); end
        // New ratio (keep all) applies only now that the drain was idle.
        src1[wr1] = 32'h20; src1[wr1 + 1] = 32'h21;
        wr1 = wr1 + 2;
        for (int c = 0; c < 100 && r1.size() < 5; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (r1.size() != 5) begin errors++; $display("FAIL dec_relatch_count got %0d exp 5", r1.size()); end
        if (r1.size() == 5) begin
            checks++; if (r1[3] !== 32'h20 || r1[4] !== 32'h21) begin
                errors++; $display("FAIL dec_relatch_data got %h %h exp 20 21", r1[3], r1[4]);
            end
        end
        checks++; if (cnt1 !== 16'd35) begin errors++; $display("FAIL dec_relatch_cnt got %0d exp 35", cnt1); end
    endtask

    task automatic test_rdlat3();
        r3.delete();
        m_ready = 1'b1; decim = 4'd0;
        base = pops3;
        @(negedge clk);
        for (int i = 0; i < 12; i++) src3[wr3 + i] = 32'h300 + 32'(i);
        wr3 = wr3 + 12;
        for (int c = 0; c < 300 && !(r3.size() >= 12 && !busy3); c++) begin
            if (c % 2 == 0) force_empty3 = ~force_empty3;
            @(negedge clk);
        end
        force_empty3 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (r3.size() != 12) begin errors++; $display("FAIL lat3_count got %0d exp 12", r3.size()); end
        for (int i = 0; i < 12 && i < r3.size(); i++) begin
            checks++;
            if (r3[i] !== 32'h300 + 32'(i)) begin errors++; $display("FAIL lat3_data[%0d] got %h exp %h", i, r3[i], 32'h300 + 32'(i)); end
        end
        checks++; if (pops3 - base != 12) begin errors++; $display("FAIL lat3_pops got %0d exp 12", pops3 - base); end
        checks++; if (cnt3 !== 16'd12) begin errors++; $display("FAIL lat3_cnt got %0d exp 12", cnt3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL lat3_busy got %h exp 0", busy3); end
    endtask

`ifdef FIR_DRAIN_PEAK_EN
    task automatic test_peak();
        r1.delete();
        m_ready = 1'b1; decim = 4'd0;
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        checks++; if (peak1 !== 31'h0) begin errors++; $display("FAIL peak_init got %h exp 0", peak1); end
        src1[wr1] = 32'h5; src1[wr1 + 1] = 32'hFFFF_FFF7;
        src1[wr1 + 2] = 32'h8000_0000; src1[wr1 + 3] = 32'h7;
        wr1 = wr1 + 4;
        for (int c = 0; c < 100 && !(r1.size() >= 4 && !busy1); c++) @(negedge clk);
        checks++; if (peak1 !== 31'h7FFF_FFFF) begin errors++; $display("FAIL peak_sat got %h exp 7fffffff", peak1); end
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        checks++; if (peak1 !== 31'h0) begin errors++; $display("FAIL peak_clr got %h exp 0", peak1); end
        src1[wr1] = 32'hFFFF_FFFD;
        wr1 = wr1 + 1;
        for (int c = 0; c < 100 && !(r1.size() >= 5 && !busy1); c++) @(negedge clk);
        checks++; if (peak1 !== 31'h3) begin errors++; $display("FAIL peak_neg3 got %h exp 3", peak1); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        wr1 = 0; rd1 = 0; pops1 = 0;
        wr3 = 0; rd3 = 0; pops3 = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_decim();
        test_rdlat3();
`ifdef FIR_DRAIN_PEAK_EN
        test_peak();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
